gpu_stencil_requester: RTL

//  Initiator side of the stencil cache interface. Accepts 16-pixel span requests from the pixel pipeline,

---
 rtl/gpu_stencil_pkg.sv | 24 ++
 rtl/gpu_stencil_requester.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gpu_stencil_pkg.sv
// Shared widths, the span request record and the stencil word address packing
// used by the stencil requester.
package gpu_stencil_pkg;

    localparam int X_W    = 6;
    localparam int Y_W    = 9;
    localparam int ADDR_W = Y_W + X_W;
    localparam int SPAN_W = 16;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [SPAN_W-1:0] pix;
        logic [SPAN_W-1:0] bits;
        logic              check;
        logic              frc;
    } span_req_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                    input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/gpu_stencil_requester.sv
// Stencil cache initiator: reads the stencil word for a 16-pixel span, applies
// mask-check / mask-set and issues the masked write-back in request order.
module gpu_stencil_requester
    import gpu_stencil_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [X_W-1:0]    req_x_i,
    input  logic [Y_W-1:0]    req_y_i,
    input  logic [SPAN_W-1:0] req_pix_i,
    input  logic [SPAN_W-1:0] req_bits_i,
    input  logic              req_check_i,
    input  logic              req_force_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [SPAN_W-1:0] res_wmask_o,
    output logic              stencil_rd_req_o,
    output logic [ADDR_W-1:0] stencil_rd_addr_o,
    input  logic [SPAN_W-1:0] stencil_rd_value_i,
    output logic              stencil_wr_req_o,
    output logic [ADDR_W-1:0] stencil_wr_addr_o,
    output logic [SPAN_W-1:0] stencil_wr_mask_o,
    output logic [SPAN_W-1:0] stencil_wr_value_o,
    input  logic              stencil_error_i,
    output logic              error_o
);

    logic              s1_valid_q, s1_valid_d;
    span_req_t         s1_req_q;
    logic              s2_valid_q, s2_valid_d;
    span_req_t         s2_req_q;
    logic [SPAN_W-1:0] s2_stencil_q;
    logic              wr_last_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              error_q, error_d;

    span_req_t         in_req;
    logic [ADDR_W-1:0] in_addr, s2_addr;
    logic [SPAN_W-1:0] blk, wmask, wr_value;
    logic              needwr, s2_stall, res_valid, fire, wr_fire, hazard, ready, acc, guard;

    always_comb begin
        in_req.x     = req_x_i;
        in_req.y     = req_y_i;
        in_req.pix   = req_pix_i;
        in_req.bits  = req_bits_i;
        in_req.check = req_check_i;
        in_req.frc   = req_force_i;
    end

    assign in_addr  = pack_addr(req_y_i, req_x_i);
    assign s2_addr  = pack_addr(s2_req_q.y, s2_req_q.x);

    assign blk      = s2_req_q.pix & s2_stencil_q & {SPAN_W{s2_req_q.check}};
    assign wmask    = s2_req_q.pix & ~blk;
    assign needwr   = |wmask;
    assign wr_value = s2_req_q.bits | {SPAN_W{s2_req_q.frc}};

    // A write must never follow a write on the very next cycle; the result waits instead.
    assign s2_stall  = needwr & wr_last_q;
    assign res_valid = s2_valid_q & ~s2_stall & ~rst_i;
    assign fire      = res_valid & res_ready_i;
    assign wr_fire   = fire & needwr;
    assign guard     = s2_valid_q & res_ready_i & s2_stall;

    // Block a read of a word whose write is issuing now or landed last cycle.
    assign hazard = (wr_fire & (s2_addr == in_addr)) | (wr_last_q & (wr_addr_q == in_addr));
    assign ready  = ~rst_i & ~s1_valid_q & (~s2_valid_q | fire) & ~hazard;
    assign acc    = req_valid_i & ready;

    always_comb begin
        s1_valid_d = acc;
        s2_valid_d = s2_valid_q;
        if (s1_valid_q) begin
            s2_valid_d = 1'b1;
        end else if (fire) begin
            s2_valid_d = 1'b0;
        end
        error_d = error_q | stencil_error_i | guard;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            wr_last_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            wr_last_q  <= wr_fire;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            s1_req_q <= in_req;
        end
        if (s1_valid_q) begin
            s2_req_q     <= s1_req_q;
            s2_stencil_q <= stencil_rd_value_i;
        end
        if (wr_fire) begin
            wr_addr_q <= s2_addr;
        end
    end

    assign req_ready_o        = ready;
    assign res_valid_o        = res_valid;
    assign res_wmask_o        = wmask;
    assign stencil_rd_req_o   = acc;
    assign stencil_rd_addr_o  = in_addr;
    assign stencil_wr_req_o   = wr_fire;
    assign stencil_wr_addr_o  = s2_addr;
    assign stencil_wr_mask_o  = wmask;
    assign stencil_wr_value_o = wr_value;
    assign error_o            = error_q;

endmodule
